// File: rtl/load_unit_if.sv
// Data-memory read port shared by the load unit and memory.
// master drives the request; slave returns data and ready.
interface load_unit_if;
  logic [31:0] address;
  logic        read_enable;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  modport master (
    output address,
    output read_enable,
    input  mem_read_data,
    input  mem_ready
  );

  modport slave (
    input  address,
    input  read_enable,
    output mem_read_data,
    output mem_ready
  );
endinterface

// File: rtl/load_unit.sv
// MIPS load unit: decode, effective address, memory read, lane extract.
// Optional REQ watchdog enabled by defining LOAD_TIMEOUT_EN.
module load_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic [31:0] Read_data1,
  load_unit_if.master mem,
  output logic        busy,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_back_data,
  output logic        done,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  typedef enum logic [2:0] {
    IDLE, REQ, WB, FAULT, ABORT
  } state_t;

  state_t state, next;

  logic [5:0]  opc, op;
  logic [31:0] ea, addr, ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        is_load, mis, accept, rd_en;

  logic unused_bits;
  assign unused_bits = ^{instruction[25:21],
                         CNT_WIDTH'(TIMEOUT_CYCLES)};

  assign opc = instruction[31:26];
  assign ea  = Read_data1
             + {{16{instruction[15]}}, instruction[15:0]};

  always_comb begin
    is_load = 1'b0;
    mis     = 1'b0;
    unique case (1'b1)
      (opc == OP_LW): begin
        is_load = 1'b1;
        mis     = |ea[1:0];
      end
      (opc == OP_LH),
      (opc == OP_LHU): begin
        is_load = 1'b1;
        mis     = ea[0];
      end
      (opc == OP_LB),
      (opc == OP_LBU): is_load = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && instr_valid && is_load;

  assign lane_b = mem.mem_read_data[{addr[1:0], 3'b000} +: 8];
  assign lane_h = addr[1] ? mem.mem_read_data[31:16]
                          : mem.mem_read_data[15:0];

  always_comb begin
    ext = mem.mem_read_data;
    unique case (1'b1)
      (op == OP_LB):  ext = {{24{lane_b[7]}}, lane_b};
      (op == OP_LBU): ext = {24'b0, lane_b};
      (op == OP_LH):  ext = {{16{lane_h[15]}}, lane_h};
      (op == OP_LHU): ext = {16'b0, lane_h};
      default: ;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt;
  logic                 limit;

  assign limit = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // cnt counts REQ edges already spent without mem_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state != REQ)
      cnt <= '0;
    else if (!mem.mem_ready)
      cnt <= cnt + CNT_WIDTH'(1);
  end

  assign timeout = (state == ABORT);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    next       = state;
    rd_en      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    reg_write  = 1'b0;
    misaligned = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept)
          next = mis ? FAULT : REQ;
      end
      REQ: begin
        rd_en = 1'b1;
        if (mem.mem_ready)
          next = WB;
`ifdef LOAD_TIMEOUT_EN
        else if (limit)
          next = ABORT;
`endif
      end
      WB: begin
        done      = 1'b1;
        reg_write = |write_reg;
        next      = IDLE;
      end
      FAULT: begin
        misaligned = 1'b1;
        next       = IDLE;
      end
      ABORT:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      addr            <= '0;
      op              <= '0;
      write_reg       <= '0;
      write_back_data <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr      <= ea;
        op        <= opc;
        write_reg <= instruction[20:16];
      end
      if (state == REQ && mem.mem_ready)
        write_back_data <= ext;
    end
  end

  assign mem.address     = addr;
  assign mem.read_enable = rd_en;

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: vector table, random model, corner sequences.
// Timeout checks follow LOAD_TIMEOUT_EN with TIMEOUT_CYCLES=4.
module tb_load_unit;

  localparam int TO = 4;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] Read_data1;
  logic        busy, reg_write, done, misaligned, timeout;
  logic [4:0]  write_reg;
  logic [31:0] write_back_data;

  load_unit_if mif ();

  load_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .Read_data1      (Read_data1),
    .mem             (mif),
    .busy            (busy),
    .reg_write       (reg_write),
    .write_reg       (write_reg),
    .write_back_data (write_back_data),
    .done            (done),
    .misaligned      (misaligned),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] base;
    logic [15:0] imm;
    logic [31:0] word;
    int          waits;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, 5'd4, rt, imm};
  endfunction

  // Reference: effective address and lane value by plain arithmetic
  function automatic void model(input logic [5:0] op,
                                input logic [31:0] base,
                                input logic [15:0] imm,
                                input logic [31:0] w,
                                output bit mis,
                                output logic [31:0] addr,
                                output logic [31:0] data);
    int s;
    int k;
    longint v;
    s    = $signed(imm);
    addr = base + s;
    k    = int'(addr % 4);
    mis  = 0;
    data = 0;
    if (op == LW) begin
      mis  = (k != 0);
      data = w;
    end else if (op == LH || op == LHU) begin
      mis = (k % 2 != 0);
      v   = (w >> (16 * (k / 2))) & 32'hFFFF;
      if (op == LH && v >= 32768) v -= 65536;
      data = 32'(v);
    end else if (op == LB || op == LBU) begin
      v = (w >> (8 * k)) & 32'hFF;
      if (op == LB && v >= 128) v -= 256;
      data = 32'(v);
    end
  endfunction

  task automatic do_load(input string nm, input logic [5:0] op,
                         input logic [4:0] rt,
                         input logic [31:0] base,
                         input logic [15:0] imm,
                         input logic [31:0] word, input int waits,
                         input bit emis, input logic [31:0] eaddr,
                         input logic [31:0] edata);
    instruction   = mk(op, rt, imm);
    Read_data1    = base;
    instr_valid   = 1'b1;
    mif.mem_ready = 1'b0;
    step;
    instr_valid = 1'b0;
    instruction = $urandom;
    Read_data1  = $urandom;
    chk({nm, " addr"}, mif.address, eaddr);
    chk({nm, " busy"}, 32'(busy), 32'd1);
    if (emis) begin
      chk({nm, " mis"}, 32'(misaligned), 32'd1);
      chk({nm, " mis_re"}, 32'(mif.read_enable), 32'd0);
      chk({nm, " mis_wr"}, 32'(reg_write), 32'd0);
      step;
      chk({nm, " mis_end"}, 32'(misaligned), 32'd0);
      chk({nm, " mis_idle"}, 32'(busy), 32'd0);
    end else begin
      chk({nm, " re"}, 32'(mif.read_enable), 32'd1);
      chk({nm, " nomis"}, 32'(misaligned), 32'd0);
      for (int i = 0; i < waits; i++) begin
        mif.mem_read_data = $urandom;
        step;
        chk({nm, " re_wait"}, 32'(mif.read_enable), 32'd1);
        chk({nm, " addr_wait"}, mif.address, eaddr);
      end
      mif.mem_ready     = 1'b1;
      mif.mem_read_data = word;
      step;
      mif.mem_ready     = 1'b0;
      mif.mem_read_data = $urandom;
      chk({nm, " done"}, 32'(done), 32'd1);
      chk({nm, " wr"}, 32'(reg_write), 32'(rt != 0));
      chk({nm, " rt"}, 32'(write_reg), 32'(rt));
      chk({nm, " data"}, write_back_data, edata);
      chk({nm, " re_off"}, 32'(mif.read_enable), 32'd0);
      step;
      chk({nm, " done_end"}, 32'(done), 32'd0);
      chk({nm, " wr_end"}, 32'(reg_write), 32'd0);
      chk({nm, " idle"}, 32'(busy), 32'd0);
      chk({nm, " hold"}, write_back_data, edata);
    end
  endtask

  initial begin
    logic [5:0]  ops [5];
    logic [5:0]  op;
    logic [31:0] base, word, eaddr, edata;
    logic [15:0] imm;
    logic [4:0]  rt;
    bit          emis;
    int          n, guard;

    ops = '{LW, LH, LHU, LB, LBU};

    vt[0] = '{LW,  5'd9, 32'h0, 16'h0004, 32'h12345678, 1,
              0, 32'h00000004, 32'h12345678};
    vt[1] = '{LB,  5'd3, 32'h20, 16'hFFFF, 32'h80FF0000, 0,
              0, 32'h0000001F, 32'hFFFFFF80};
    vt[2] = '{LBU, 5'd4, 32'h20, 16'hFFFF, 32'h80FF0000, 0,
              0, 32'h0000001F, 32'h00000080};
    vt[3] = '{LH,  5'd2, 32'h1C, 16'h0003, 32'h0, 0,
              1, 32'h0000001F, 32'h0};
    vt[4] = '{LW,  5'd0, 32'h100, 16'h0008, 32'hDEADBEEF, 0,
              0, 32'h00000108, 32'hDEADBEEF};
    vt[5] = '{LHU, 5'd6, 32'h1000, 16'hFFFE, 32'h80017FFF, 2,
              0, 32'h00000FFE, 32'h00008001};
    vt[6] = '{LH,  5'd7, 32'hFFFFFFFE, 16'h0004, 32'h9ABC1234, 1,
              0, 32'h00000002, 32'hFFFF9ABC};
    vt[7] = '{LW,  5'd8, 32'h1, 16'h0000, 32'h0, 0,
              1, 32'h00000001, 32'h0};

    reset             = 1'b0;
    instruction       = '0;
    instr_valid       = 1'b0;
    Read_data1        = '0;
    mif.mem_ready     = 1'b0;
    mif.mem_read_data = '0;
    step;
    step;
    chk("rst addr", mif.address, 32'd0);
    chk("rst re", 32'(mif.read_enable), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wbd", write_back_data, 32'd0);
    chk("rst flags", {27'd0, reg_write, done, misaligned,
                      timeout, 1'b0}, 32'd0);
    chk("rst rt", 32'(write_reg), 32'd0);
    reset = 1'b1;
    step;

    for (int i = 0; i < 8; i++)
      do_load($sformatf("vec%0d", i), vt[i].op, vt[i].rt,
              vt[i].base, vt[i].imm, vt[i].word, vt[i].waits,
              vt[i].mis, vt[i].addr, vt[i].data);

    // store opcode must be ignored
    instruction = mk(SW, 5'd5, 16'h0010);
    instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    chk("sw busy", 32'(busy), 32'd0);
    chk("sw re", 32'(mif.read_enable), 32'd0);
    step;
    chk("sw busy2", 32'(busy), 32'd0);

    // second load while busy is dropped
    instruction = mk(LW, 5'd5, 16'h0040);
    Read_data1  = 32'h0;
    instr_valid = 1'b1;
    step;
    instruction       = mk(LW, 5'd7, 16'h0080);
    mif.mem_ready     = 1'b1;
    mif.mem_read_data = 32'hCAFEF00D;
    step;
    instr_valid   = 1'b0;
    mif.mem_ready = 1'b0;
    chk("drop rt", 32'(write_reg), 32'd5);
    chk("drop data", write_back_data, 32'hCAFEF00D);
    chk("drop done", 32'(done), 32'd1);
    step;
    chk("drop idle", 32'(busy), 32'd0);
    chk("drop addr", mif.address, 32'h40);

    // reset in the middle of REQ
    instruction = mk(LW, 5'd12, 16'h0010);
    Read_data1  = 32'h100;
    instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    step;
    #2 reset = 1'b0;
    #1;
    chk("arst re", 32'(mif.read_enable), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst addr", mif.address, 32'd0);
    chk("arst rt", 32'(write_reg), 32'd0);
    chk("arst wbd", write_back_data, 32'd0);
    mif.mem_ready     = 1'b1;
    mif.mem_read_data = 32'h55AA55AA;
    step;
    reset = 1'b1;
    step;
    chk("arst nowr", 32'(reg_write), 32'd0);
    chk("arst nodone", 32'(done), 32'd0);
    chk("arst idle", 32'(busy), 32'd0);
    chk("arst wbd2", write_back_data, 32'd0);
    mif.mem_ready = 1'b0;
    step;

`ifdef LOAD_TIMEOUT_EN
    instruction = mk(LW, 5'd10, 16'h0000);
    Read_data1  = 32'h40;
    instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    n     = 0;
    guard = 0;
    while (!timeout && guard < 12) begin
      if (mif.read_enable) n++;
      chk("to nowr", 32'(reg_write), 32'd0);
      step;
      guard++;
    end
    chk("to fire", 32'(timeout), 32'd1);
    chk("to req_cycles", 32'(n), 32'(TO));
    chk("to re", 32'(mif.read_enable), 32'd0);
    chk("to wr", 32'(reg_write), 32'd0);
    step;
    chk("to end", 32'(timeout), 32'd0);
    chk("to idle", 32'(busy), 32'd0);

    instruction = mk(LW, 5'd11, 16'h0004);
    Read_data1  = 32'h40;
    instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    for (int i = 0; i < TO - 1; i++) step;
    mif.mem_ready     = 1'b1;
    mif.mem_read_data = 32'h0BADF00D;
    step;
    mif.mem_ready = 1'b0;
    chk("to race done", 32'(done), 32'd1);
    chk("to race to", 32'(timeout), 32'd0);
    chk("to race data", write_back_data, 32'h0BADF00D);
    step;
`else
    instruction = mk(LW, 5'd10, 16'h0000);
    Read_data1  = 32'h40;
    instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (timeout || !mif.read_enable) begin
        chk("wait re", 32'(mif.read_enable), 32'd1);
        chk("wait to", 32'(timeout), 32'd0);
        break;
      end
    end
    chk("wait hold", 32'(mif.read_enable), 32'd1);
    mif.mem_ready     = 1'b1;
    mif.mem_read_data = 32'h0BADF00D;
    step;
    mif.mem_ready = 1'b0;
    chk("wait done", 32'(done), 32'd1);
    chk("wait data", write_back_data, 32'h0BADF00D);
    step;
`endif

    for (int i = 0; i < 40; i++) begin
      op   = ops[$urandom_range(0, 4)];
      rt   = 5'($urandom);
      base = $urandom;
      imm  = 16'($urandom);
      word = $urandom;
      model(op, base, imm, word, emis, eaddr, edata);
      do_load($sformatf("rnd%0d", i), op, rt, base, imm, word,
              $urandom_range(0, 3), emis, eaddr, edata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
